// File: rtl/map_pkg.sv
// map_pkg: shared tile-map constants, FSM state type and address helpers.
// Used by the pellet updater and by the render-side map readers.
// Macro SCORE_BCD_EN: when defined, to_score() encodes point values as packed BCD.
package map_pkg;

    localparam int MAP_ADDR_W = 12;

    localparam logic [3:0] TILE_EMPTY  = 4'h0;
    localparam logic [3:0] TILE_WALL   = 4'h1;
    localparam logic [3:0] TILE_PELLET = 4'h2;
    localparam logic [3:0] TILE_POWER  = 4'h3;

    typedef enum logic [2:0] {IDLE, RD, WAIT, CHECK, WR} state_t;

    // row*40 + col without a multiplier
    function automatic logic [MAP_ADDR_W-1:0] map_addr(input logic [4:0] row, input logic [5:0] col);
        return ({7'b0, row} << 5) + ({7'b0, row} << 3) + {6'b0, col};
    endfunction

    // Point value in the same encoding as the score register
    function automatic logic [15:0] to_score(input int v);
`ifdef SCORE_BCD_EN
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`else
        return 16'(v);
`endif
    endfunction

endpackage

// File: rtl/score_accum.sv
// score_accum: saturating score adder, binary or four-digit BCD.
// Ports: score (current value), add (increment, same encoding), sum (saturated result).
// Macro SCORE_BCD_EN: defined -> per-digit BCD add saturating at 16'h9999;
// undefined -> binary add saturating at 16'hFFFF.
module score_accum (
    input  logic [15:0] score,
    input  logic [15:0] add,
    output logic [15:0] sum
);
`ifdef SCORE_BCD_EN
    logic [4:0] t;
    logic       c;
    always_comb begin
        sum = '0;
        c = 1'b0;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, score[4*i +: 4]} + {1'b0, add[4*i +: 4]} + {4'b0, c};
            c = t > 5'd9;
            sum[4*i +: 4] = c ? 4'(t - 5'd10) : t[3:0];
        end
        if (c) sum = 16'h9999;
    end
`else
    logic [16:0] t;
    assign t = {1'b0, score} + {1'b0, add};
    assign sum = t[16] ? 16'hFFFF : t[15:0];
`endif
endmodule

// File: rtl/map_pellet_updater.sv
// map_pellet_updater: per-frame pellet eater owning the tile RAM write port.
// Inputs: Clk, Reset (sync, active-high), frame_tick, level_restart, pac_col, pac_row, ram_rd_data.
// Outputs: ram_rd_addr, ram_wr_addr, ram_wr_data, ram_we, score, pellets_left,
//          power_pulse, level_clear (sticky), busy.
// Macro SCORE_BCD_EN: score is kept as four packed BCD digits instead of binary.
module map_pellet_updater
    import map_pkg::*;
#(
    parameter int MAP_COLS      = 40,
    parameter int MAP_ROWS      = 30,
    parameter int PELLET_TOTAL  = 244,
    parameter int PELLET_POINTS = 10,
    parameter int POWER_POINTS  = 50
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_tick,
    input  logic                  level_restart,
    input  logic [5:0]            pac_col,
    input  logic [4:0]            pac_row,
    output logic [MAP_ADDR_W-1:0] ram_rd_addr,
    input  logic [3:0]            ram_rd_data,
    output logic [MAP_ADDR_W-1:0] ram_wr_addr,
    output logic [3:0]            ram_wr_data,
    output logic                  ram_we,
    output logic [15:0]           score,
    output logic [8:0]            pellets_left,
    output logic                  power_pulse,
    output logic                  level_clear,
    output logic                  busy
);
    localparam logic [15:0] PELLET_ADD = to_score(PELLET_POINTS);
    localparam logic [15:0] POWER_ADD  = to_score(POWER_POINTS);

    state_t                state;
    logic [MAP_ADDR_W-1:0] addr;
    logic [15:0]           add;
    logic [15:0]           sum;
    logic                  in_range;
    logic                  is_pellet;
    logic                  is_power;

    assign in_range  = pac_col < 6'(MAP_COLS) && pac_row < 5'(MAP_ROWS);
    assign is_pellet = ram_rd_data == TILE_PELLET;
    assign is_power  = ram_rd_data == TILE_POWER;
    assign add       = is_power ? POWER_ADD : PELLET_ADD;

    // One latched address serves both ports; it is stable from RD until the next tick.
    assign ram_rd_addr = addr;
    assign ram_wr_addr = addr;
    assign ram_wr_data = TILE_EMPTY;
    assign busy        = state != IDLE;

    score_accum u_score_accum (
        .score(score),
        .add  (add),
        .sum  (sum)
    );

    // Write-side effects are registered on the CHECK->WR transition so they
    // appear together with ram_we during the single WR cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            addr         <= '0;
            ram_we       <= 1'b0;
            power_pulse  <= 1'b0;
            score        <= '0;
            pellets_left <= 9'(PELLET_TOTAL);
            level_clear  <= 1'b0;
        end else begin
            ram_we      <= 1'b0;
            power_pulse <= 1'b0;
            if (level_restart) begin
                state        <= IDLE;
                pellets_left <= 9'(PELLET_TOTAL);
                level_clear  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (frame_tick && in_range) begin
                        addr  <= map_addr(pac_row, pac_col);
                        state <= RD;
                    end
                    RD:    state <= WAIT;
                    WAIT:  state <= CHECK;
                    CHECK: if (is_pellet || is_power) begin
                        state       <= WR;
                        ram_we      <= 1'b1;
                        power_pulse <= is_power;
                        score       <= sum;
                        if (pellets_left != 9'd0) pellets_left <= pellets_left - 9'd1;
                        if (pellets_left == 9'd1) level_clear <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
